// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate L1 data cache.
// Accepts one load/store at a time from the LSQ. Load hits are answered the
// cycle after acceptance; load misses refill a 4-byte line with two halfword
// reads from dataMemory; halfword loads that straddle a line go uncached;
// every store is forwarded to dataMemory. Byte order is big-endian
// (line byte 0 sits in line[31:24]).
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   req_valid/req_ready       LSQ handshake (ready only while idle)
//   req_write, req_size       1=store/0=load, 1=byte/0=halfword
//   req_addr/wdata/pc         request address, store data, instruction PC
//   resp_valid/data/pc        one-cycle completion pulse with load data
//   mem_*                     dataMemory port (read/write strobes, address,
//                             store data/size, PC), mem_rdata returns read data
//                             the cycle after mem_read
//   hit_count, miss_count     saturating load hit / miss statistics
module data_cache #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_size,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [31:0]      req_pc,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [31:0]      resp_pc,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_store_size,
    output logic             mem_cache_miss,
    output logic             mem_from_lsq,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [31:0]      mem_pc,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, MISS0, MISS1, FILL, UNC0, UNC1, STORE} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags  [LINES];
    logic [31:0]      lines [LINES];

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_pc;
    logic        lat_size;
    logic [15:0] cap_hi;

    logic [1:0]            req_off;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  req_hit;
    logic                  req_unc;
    logic                  accept;
    logic [INDEX_BITS-1:0] lat_idx;
    logic [TAG_W-1:0]      lat_tag;
    logic [31:0]           fill_line;
    logic                  unused_rdata;

    assign req_off   = req_addr[1:0];
    assign req_idx   = req_addr[INDEX_BITS+1:2];
    assign req_tag   = req_addr[31:INDEX_BITS+2];
    assign req_hit   = valid[req_idx] && (tags[req_idx] == req_tag);
    // A halfword at offset 3 spans two lines, so it bypasses the cache.
    assign req_unc   = !req_size && (req_off == 2'd3);
    assign accept    = req_valid && (state == IDLE);
    assign lat_idx   = lat_addr[INDEX_BITS+1:2];
    assign lat_tag   = lat_addr[31:INDEX_BITS+2];
    assign fill_line = {cap_hi, mem_rdata[15:0]};
    assign unused_rdata = ^mem_rdata[31:16];

    function automatic logic [31:0] extract(input logic [31:0] line,
                                            input logic [1:0]  off,
                                            input logic        size);
        logic [1:0] off1;
        logic [7:0] b0;
        logic [7:0] b1;
        off1 = off + 2'd1;
        b0 = line[8*(3-int'(off)) +: 8];
        b1 = line[8*(3-int'(off1)) +: 8];
        return size ? {24'h0, b0} : {16'h0, b0, b1};
    endfunction

    // Store-hit update; a halfword at offset 3 only touches the byte that lives
    // in this line.
    function automatic logic [31:0] merge(input logic [31:0] line,
                                          input logic [1:0]  off,
                                          input logic        size,
                                          input logic [31:0] wdata);
        logic [31:0] r;
        logic [1:0]  off1;
        r    = line;
        off1 = off + 2'd1;
        if (size) begin
            r[8*(3-int'(off)) +: 8] = wdata[7:0];
        end else begin
            r[8*(3-int'(off)) +: 8] = wdata[15:8];
            if (off != 2'd3) r[8*(3-int'(off1)) +: 8] = wdata[7:0];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            valid      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_pc    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_pc    <= req_pc;
                        lat_size  <= req_size;
                        if (req_write) begin
                            if (req_hit)
                                lines[req_idx] <= merge(lines[req_idx], req_off, req_size, req_wdata);
                        end else if (!req_unc && req_hit) begin
                            resp_valid <= 1'b1;
                            resp_data  <= extract(lines[req_idx], req_off, req_size);
                            resp_pc    <= req_pc;
                            if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        end
                    end
                end
                MISS1: cap_hi <= mem_rdata[15:0];
                FILL: begin
                    lines[lat_idx] <= fill_line;
                    tags[lat_idx]  <= lat_tag;
                    valid[lat_idx] <= 1'b1;
                    resp_valid     <= 1'b1;
                    resp_data      <= extract(fill_line, lat_addr[1:0], lat_size);
                    resp_pc        <= lat_pc;
                end
                UNC1: begin
                    resp_valid <= 1'b1;
                    resp_data  <= {16'h0, mem_rdata[15:0]};
                    resp_pc    <= lat_pc;
                end
                STORE: begin
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_pc    <= lat_pc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        req_ready      = (state == IDLE);
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_store_size = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write)    state_nxt = STORE;
                    else if (req_unc) state_nxt = UNC0;
                    else if (req_hit) state_nxt = IDLE;
                    else              state_nxt = MISS0;
                end
            end
            MISS0: begin
                mem_read  = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                state_nxt = MISS1;
            end
            MISS1: begin
                mem_read  = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b10};
                state_nxt = FILL;
            end
            FILL:  state_nxt = IDLE;
            UNC0: begin
                mem_read  = 1'b1;
                mem_addr  = lat_addr;
                state_nxt = UNC1;
            end
            UNC1:  state_nxt = IDLE;
            STORE: begin
                mem_write      = 1'b1;
                mem_store_size = lat_size;
                mem_wdata      = lat_wdata;
                mem_addr       = lat_addr;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        mem_cache_miss = mem_read || mem_write;
        mem_from_lsq   = 1'b0;
        mem_pc         = (mem_read || mem_write) ? lat_pc : 32'h0;
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_size = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] resp_pc;
    logic        mem_read, mem_write, mem_store_size, mem_cache_miss, mem_from_lsq;
    logic [31:0] mem_addr, mem_wdata, mem_pc;
    logic [31:0] mem_rdata = '0;
    logic [15:0] hit_count, miss_count;

    data_cache #(.INDEX_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_pc(resp_pc),
        .mem_read(mem_read), .mem_write(mem_write), .mem_store_size(mem_store_size),
        .mem_cache_miss(mem_cache_miss), .mem_from_lsq(mem_from_lsq),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
        .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // dataMemory stand-in: big-endian bytes, read data valid the cycle after mem_read.
    logic [7:0] dmem    [512];
    logic [7:0] ref_mem [512];

    always @(posedge clk) begin
        if (mem_read)
            mem_rdata <= {16'h0, dmem[mem_addr[8:0]], dmem[mem_addr[8:0] + 9'd1]};
        else
            mem_rdata <= $urandom;
        if (mem_write) begin
            if (mem_store_size) begin
                dmem[mem_addr[8:0]] = mem_wdata[7:0];
            end else begin
                dmem[mem_addr[8:0]]         = mem_wdata[15:8];
                dmem[mem_addr[8:0] + 9'd1] = mem_wdata[7:0];
            end
        end
    end

    typedef struct {
        bit          rv;
        bit          rdy;
        bit          rd;
        bit          wr;
        logic [31:0] maddr;
        bit          msize;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic [31:0] pc;
        int          hc;
        int          mc;
    } exp_t;

    exp_t q[$];

    int passed = 0;
    int total  = 0;
    logic [31:0] last_rdata = '0;

    // Reference model state: which tag each line holds, and the load counters.
    bit          tv [16];
    logic [25:0] tt [16];
    int          hc_m = 0;
    int          mc_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv)
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, e.rv});
            chk("req_ready", {31'h0, req_ready}, {31'h0, e.rdy});
            chk("mem_read", {31'h0, mem_read}, {31'h0, e.rd});
            chk("mem_write", {31'h0, mem_write}, {31'h0, e.wr});
            chk("mem_cache_miss", {31'h0, mem_cache_miss}, {31'h0, e.rd | e.wr});
            chk("mem_from_lsq", {31'h0, mem_from_lsq}, 32'h0);
            chk("hit_count", {16'h0, hit_count}, e.hc);
            chk("miss_count", {16'h0, miss_count}, e.mc);
            if (e.rd || e.wr) begin
                chk("mem_addr", mem_addr, e.maddr);
                chk("mem_pc", mem_pc, e.pc);
            end else begin
                chk("mem_addr_idle", mem_addr, 32'h0);
                chk("mem_pc_idle", mem_pc, 32'h0);
            end
            if (e.wr) begin
                chk("mem_store_size", {31'h0, mem_store_size}, {31'h0, e.msize});
                chk("mem_wdata", mem_wdata, e.mwdata);
            end
            if (e.rv) begin
                chk("resp_data", resp_data, e.rdata);
                chk("resp_pc", resp_pc, e.pc);
                last_rdata = resp_data;
            end
        end
    end

    task automatic push_idle();
        exp_t e;
        e = '{rv: 0, rdy: 1, rd: 0, wr: 0, maddr: 0, msize: 0, mwdata: 0,
              rdata: 0, pc: 0, hc: hc_m, mc: mc_m};
        q.push_back(e);
    endtask

    task automatic wait_empty();
        int k = 0;
        while (q.size() != 0 && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        total++;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expected cycles left unchecked", q.size());
            q.delete();
        end else begin
            passed++;
        end
    endtask

    // Issue one request (at posedge+2) and queue the expected cycle-by-cycle view.
    // abort_at > 0 pulls rstn low in that cycle after acceptance.
    task automatic do_req(input bit wr, input bit sz, input logic [31:0] a,
                          input logic [31:0] wd, input int abort_at);
        logic [31:0] pc;
        logic [8:0]  m;
        logic [3:0]  idx;
        logic [25:0] tg;
        logic [31:0] data;
        int          lat;
        int          hb, mb;
        int          last;
        bit          unc, miss;
        exp_t        e;
        pc   = $urandom;
        m    = a[8:0];
        idx  = a[5:2];
        tg   = a[31:6];
        hb   = hc_m;
        mb   = mc_m;
        unc  = 0;
        miss = 0;
        data = sz ? {24'h0, ref_mem[m]} : {16'h0, ref_mem[m], ref_mem[m + 9'd1]};
        if (wr) begin
            lat  = 2;
            data = 0;
            if (sz) ref_mem[m] = wd[7:0];
            else begin
                ref_mem[m] = wd[15:8];
                ref_mem[m + 9'd1] = wd[7:0];
            end
        end else if (!sz && a[1:0] == 2'd3) begin
            lat = 3; unc = 1; mc_m++;
        end else if (tv[idx] && tt[idx] == tg) begin
            lat = 1; hc_m++;
        end else begin
            lat = 4; miss = 1; mc_m++;
            tv[idx] = 1; tt[idx] = tg;
        end
        last = (abort_at > 0) ? abort_at : lat;
        for (int n = 0; n <= last; n++) begin
            e = '{rv: (n == lat), rdy: (n == 0 || n == lat), rd: 0, wr: 0,
                  maddr: 0, msize: sz, mwdata: wd, rdata: data, pc: pc,
                  hc: (n == 0) ? hb : hc_m, mc: (n == 0) ? mb : mc_m};
            if (wr && n == 1) begin e.wr = 1; e.maddr = a; end
            if (unc && n == 1) begin e.rd = 1; e.maddr = a; end
            if (miss && n == 1) begin e.rd = 1; e.maddr = {a[31:2], 2'b00}; end
            if (miss && n == 2) begin e.rd = 1; e.maddr = {a[31:2], 2'b10}; end
            q.push_back(e);
        end
        req_valid = 1; req_write = wr; req_size = sz; req_addr = a;
        req_wdata = wd; req_pc = pc;
        @(posedge clk); #2;
        req_valid = 0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) begin @(posedge clk); #2; end
            rstn = 0;
            @(posedge clk); #2;
            rstn = 1;
            for (int i = 0; i < 16; i++) tv[i] = 0;
            hc_m = 0;
            mc_m = 0;
            push_idle();
        end
        wait_empty();
    endtask

    initial begin
        bit          w, s;
        logic [31:0] a;
        for (int i = 0; i < 512; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        for (int i = 0; i < 16; i++) tv[i] = 0;
        rstn = 0;
        repeat (3) @(posedge clk);
        #2 rstn = 1;
        push_idle();
        wait_empty();

        do_req(1, 0, 32'h10, 32'h0000ABCD, 0);
        do_req(0, 0, 32'h10, 32'h0, 0);
        chk("tp_load_h10", last_rdata, 32'h0000ABCD);
        chk("tp_miss_cnt1", {16'h0, miss_count}, 32'd1);
        do_req(0, 1, 32'h11, 32'h0, 0);
        chk("tp_load_b11", last_rdata, 32'h000000CD);
        chk("tp_hit_cnt1", {16'h0, hit_count}, 32'd1);
        do_req(1, 1, 32'h11, 32'h00000077, 0);
        do_req(0, 0, 32'h10, 32'h0, 0);
        chk("tp_load_h10_upd", last_rdata, 32'h0000AB77);
        chk("tp_mem_11", {24'h0, dmem[17]}, 32'h77);
        do_req(0, 0, 32'h50, 32'h0, 0);
        do_req(0, 0, 32'h10, 32'h0, 0);
        chk("tp_conflict_miss", {16'h0, miss_count}, 32'd3);
        do_req(0, 0, 32'h13, 32'h0, 0);
        do_req(0, 1, 32'h10, 32'h0, 0);
        chk("tp_unc_keeps_line", {16'h0, hit_count}, 32'd3);
        chk("tp_unc_miss_cnt", {16'h0, miss_count}, 32'd4);
        do_req(0, 0, 32'h20, 32'h0, 2);
        chk("tp_rst_hits", {16'h0, hit_count}, 32'd0);
        do_req(0, 0, 32'h10, 32'h0, 0);
        chk("tp_rst_reload_miss", {16'h0, miss_count}, 32'd1);
        chk("tp_rst_reload_data", last_rdata, {16'h0, dmem[16], dmem[17]});

        for (int i = 0; i < 300; i++) begin
            w = ($urandom_range(0, 2) == 0);
            s = 1'($urandom);
            a = 32'($urandom_range(0, 255));
            if (w && !s && a[1:0] == 2'd3) a[1:0] = 2'd2;
            do_req(w, s, a, $urandom, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits between the load/store queue and `dataMemory`. It accepts one load or store at a time from the LSQ.
- It answers load hits in one cycle from its own arrays. On a miss it refills a 4-byte line using two halfword reads through `dataMemory`'s single port.
- Every store is forwarded to `dataMemory`.

Parameters:
- INDEX_BITS, 4: line-index width; the cache holds 2^INDEX_BITS lines of 4 bytes each.
- CNT_W, 16: width of the hit and miss statistic counters.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- req_valid  in  1  LSQ request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  1  0 = halfword (16-bit), 1 = byte
- req_addr  in  32  byte address
- req_wdata  in  32  store data; a halfword store uses [15:0], a byte store uses [7:0]
- req_pc  in  32  instruction PC
- resp_valid  out  1  one-cycle pulse; load data or store acknowledge
- resp_data  out  32  load result, zero-extended; 0 for stores
- resp_pc  out  32  PC of the completed request
- mem_read  out  1  to dataMemory memRead
- mem_write  out  1  to dataMemory memWrite
- mem_store_size  out  1  to dataMemory storeSize
- mem_cache_miss  out  1  to dataMemory cacheMiss; high whenever mem_read or mem_write is high
- mem_from_lsq  out  1  tied 0
- mem_addr  out  32  to dataMemory address
- mem_wdata  out  32  to dataMemory dataSw
- mem_pc  out  32  to dataMemory PC_in
- mem_rdata  in  32  from dataMemory lwData; data is valid the cycle after mem_read is issued
- hit_count  out  CNT_W  number of load hits, saturating
- miss_count  out  CNT_W  number of load misses (refill plus uncached), saturating

Behaviour:
- Byte order is big-endian.
  - In a line, byte 0 is at line[31:24].
  - From memory, mem_rdata[15:8] is the byte at mem_addr and mem_rdata[7:0] is the byte at mem_addr+1.
- Address split: offset = addr[1:0], index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- Arrays: valid, tag and data per line. Reads are combinational on req_addr; writes happen on clk.
- Reset (rstn=0 at a posedge), including in the middle of an operation:
  - All valid bits cleared; state goes to IDLE.
  - The in-flight request is dropped with no response.
  - resp_valid, resp_data, resp_pc, all mem_* outputs and both counters go to 0.
- The request is accepted on a posedge where req_valid & req_ready; call that edge T. Address, size, data and PC are latched at T.
- FSM states: IDLE, MISS0, MISS1, FILL, UNC0, UNC1, STORE.
- IDLE:
  - Load hit: resp_data and resp_pc are registered at T, so resp_valid=1 in cycle T+1. hit_count increments. State stays IDLE.
    - Halfword result = {16'b0, byte[off], byte[off+1]}; byte result = {24'b0, byte[off]}.
  - Halfword load with offset==3 (crosses the line boundary): never cached. miss_count increments; go to UNC0.
  - Any other load miss: miss_count increments; go to MISS0.
  - Store: go to STORE. If the store hits, the cached bytes are updated at T (same byte placement as loads).
- MISS0:
  - mem_read=1, mem_addr = line base (addr & ~3).
  - Go to MISS1.
- MISS1:
  - Capture mem_rdata[15:0] as line bytes 0-1.
  - mem_read=1, mem_addr = base+2.
  - Go to FILL.
- FILL:
  - Write the line as {captured, mem_rdata[15:0]}, set tag, set valid.
  - Register the response, taking the result from the assembled line.
  - resp_valid is high in cycle T+4; back to IDLE.
- UNC0:
  - mem_read=1, mem_addr = req_addr.
  - Go to UNC1.
- UNC1:
  - resp_data = {16'b0, mem_rdata[15:0]}; resp_valid in cycle T+3.
  - The cache is not modified. Back to IDLE.
- STORE:
  - mem_write=1, mem_store_size = req_size, mem_wdata = req_wdata, mem_addr = req_addr, for exactly one cycle.
  - A store miss does not allocate.
  - resp_valid in cycle T+2 with resp_data=0; back to IDLE.
- mem_pc = latched req_pc whenever any mem_* strobe is high; otherwise mem_* outputs are 0.
- req_ready=0 in every state except IDLE, so only one request is outstanding at a time.
- Counters stop at all-ones (saturating).

Test Plan:
- Reset, then store halfword 0xABCD at 0x10 -> cycle T+1: mem_write=1, mem_store_size=0, mem_addr=0x10, mem_cache_miss=1; resp_valid at T+2; the line is not allocated.
- Load halfword 0x10 -> two mem_reads, to 0x10 then 0x12; resp_data=0x0000ABCD at T+4; miss_count=1.
- Load byte 0x11 -> resp_data=0x000000CD at T+1, no mem_* activity; hit_count=1. Then store byte 0x77 at 0x11 (hit) and load halfword 0x10 -> 0x0000AB77 at T+1, and memory holds 0x77 at 0x11.
- Conflict (INDEX_BITS=4): load 0x50 (same index as 0x10) -> refill, evicting the 0x10 line; a following load of 0x10 misses again.
- Halfword load at 0x13 -> single mem_read at 0x13, response at T+3, the line at index 4 is unchanged; req_ready stays low until resp_valid.
- Assert rstn=0 during MISS1 -> no resp_valid; next cycle req_ready=1, counters=0, and a reload of a previously cached address misses.
